// File: rtl/branch_predict_ctrl.sv
// Branch predictor with a table of 2-bit saturating counters: predicts in ID,
// resolves and trains in EX, and keeps branch/mispredict statistics.
module branch_predict_ctrl #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_id_valid,
    input  logic             i_id_is_branch,
    input  logic [XLEN-1:0]  i_id_pc,
    input  logic [XLEN-1:0]  i_id_target,
    output logic             o_id_pred_taken,
    output logic             o_id_redirect,
    output logic [XLEN-1:0]  o_id_redirect_pc,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_branch,
    input  logic [XLEN-1:0]  i_ex_pc,
    input  logic [XLEN-1:0]  i_ex_target,
    input  logic             i_ex_pred_taken,
    input  logic             i_ex_branch,
    output logic             o_flush,
    output logic             o_ex_redirect,
    output logic [XLEN-1:0]  o_ex_redirect_pc,
    output logic [CNT_W-1:0] o_branch_count,
    output logic [CNT_W-1:0] o_mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             id_act;
    logic             ex_act;
    logic             mispredict;
    logic             unused_id_pc_bits;

    assign id_idx = i_id_pc[2 +: IDX_W];
    assign ex_idx = i_ex_pc[2 +: IDX_W];

    // Only the index field of the ID PC selects a counter; the rest aliases.
    assign unused_id_pc_bits = ^{i_id_pc[1:0], i_id_pc[XLEN-1:IDX_W+2]};

    always_comb begin
        id_act           = i_id_valid & i_id_is_branch & ~i_stall;
        ex_act           = i_ex_valid & i_ex_is_branch & ~i_stall;
        mispredict       = ex_act & (i_ex_branch != i_ex_pred_taken);
        o_id_pred_taken  = id_act & bht[id_idx][1];
        // An EX correction overrides any younger ID redirect in the same cycle.
        o_id_redirect    = o_id_pred_taken & ~mispredict;
        o_id_redirect_pc = i_id_target;
        o_flush          = mispredict;
        o_ex_redirect    = mispredict;
        o_ex_redirect_pc = '0;
        if (mispredict) begin
            o_ex_redirect_pc = i_ex_branch ? i_ex_target : i_ex_pc + XLEN'(4);
        end
    end

    // ID reads the table combinationally, so a same-cycle EX write is seen
    // only from the next cycle on.
    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    bht[gi] <= 2'b01;
                end else if (ex_act && (ex_idx == IDX_W'(gi))) begin
                    if (i_ex_branch) begin
                        if (bht[gi] != 2'b11) begin
                            bht[gi] <= bht[gi] + 2'd1;
                        end
                    end else if (bht[gi] != 2'b00) begin
                        bht[gi] <= bht[gi] - 2'd1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_branch_count     <= '0;
            o_mispredict_count <= '0;
        end else if (ex_act) begin
            o_branch_count     <= o_branch_count + CNT_W'(1);
            o_mispredict_count <= o_mispredict_count + CNT_W'(mispredict);
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed vector table, an
// asynchronous reset sequence, and randomized traffic against a counter model.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_valid, id_is_branch;
    logic [31:0] id_pc, id_target;
    logic        id_pred_taken, id_redirect;
    logic [31:0] id_redirect_pc;
    logic        ex_valid, ex_is_branch;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred_taken, ex_branch;
    logic        flush, ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic [31:0] branch_count, mispredict_count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    branch_predict_ctrl #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(32)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_stall            (stall),
        .i_id_valid         (id_valid),
        .i_id_is_branch     (id_is_branch),
        .i_id_pc            (id_pc),
        .i_id_target        (id_target),
        .o_id_pred_taken    (id_pred_taken),
        .o_id_redirect      (id_redirect),
        .o_id_redirect_pc   (id_redirect_pc),
        .i_ex_valid         (ex_valid),
        .i_ex_is_branch     (ex_is_branch),
        .i_ex_pc            (ex_pc),
        .i_ex_target        (ex_target),
        .i_ex_pred_taken    (ex_pred_taken),
        .i_ex_branch        (ex_branch),
        .o_flush            (flush),
        .o_ex_redirect      (ex_redirect),
        .o_ex_redirect_pc   (ex_redirect_pc),
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count)
    );

    typedef struct {
        logic        stall;
        logic        idv, idb;
        logic [31:0] idpc, idtgt;
        logic        exv, exb;
        logic [31:0] expc, extgt;
        logic        expred, exbr;
        logic        e_pred, e_idr, e_flush;
        logic [31:0] e_rpc;
        int          e_bc, e_mc;
    } vec_t;

    vec_t vecs [19];

    // Behavioural model: counters as small integers 0..3, prediction = value >= 2.
    int          m_cnt [16];
    logic [31:0] m_bc, m_mc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; id_valid = 0; id_is_branch = 0; id_pc = 0; id_target = 0;
        ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_target = 0;
        ex_pred_taken = 0; ex_branch = 0;
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; id_valid = v.idv; id_is_branch = v.idb;
        id_pc = v.idpc; id_target = v.idtgt;
        ex_valid = v.exv; ex_is_branch = v.exb; ex_pc = v.expc; ex_target = v.extgt;
        ex_pred_taken = v.expred; ex_branch = v.exbr;
    endtask

    function automatic logic [31:0] pick_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        // stall idv idb idpc idtgt | exv exb expc extgt expred exbr | pred idr flush rpc | bc mc
        vecs[0]  = '{0,1,1,32'h100,32'h80, 0,0,32'h0,32'h0,0,0, 0,0,0,32'h0, 0,0};
        vecs[1]  = '{0,0,0,32'h0,32'h0, 1,1,32'h100,32'h80,0,1, 0,0,1,32'h80, 1,1};
        vecs[2]  = '{0,0,0,32'h0,32'h0, 1,1,32'h100,32'h80,0,1, 0,0,1,32'h80, 2,2};
        vecs[3]  = '{0,1,1,32'h100,32'h80, 1,1,32'h100,32'h80,1,1, 1,1,0,32'h0, 3,2};
        vecs[4]  = '{0,1,1,32'h100,32'h80, 0,0,32'h0,32'h0,0,0, 1,1,0,32'h0, 3,2};
        vecs[5]  = '{0,0,0,32'h0,32'h0, 1,1,32'h200,32'h300,1,0, 0,0,1,32'h204, 4,3};
        vecs[6]  = '{0,0,0,32'h0,32'h0, 1,1,32'h200,32'h300,0,0, 0,0,0,32'h0, 5,3};
        vecs[7]  = '{0,0,0,32'h0,32'h0, 1,1,32'h200,32'h300,0,0, 0,0,0,32'h0, 6,3};
        vecs[8]  = '{0,0,0,32'h0,32'h0, 1,1,32'h200,32'h300,0,0, 0,0,0,32'h0, 7,3};
        vecs[9]  = '{0,1,1,32'h200,32'h240, 1,1,32'h200,32'h240,0,1, 0,0,1,32'h240, 8,4};
        vecs[10] = '{0,1,1,32'h200,32'h240, 1,1,32'h200,32'h240,0,1, 0,0,1,32'h240, 9,5};
        vecs[11] = '{0,1,1,32'h200,32'h240, 0,0,32'h0,32'h0,0,0, 1,1,0,32'h0, 9,5};
        vecs[12] = '{0,1,1,32'h40,32'h60, 1,1,32'h40,32'h90,1,0, 1,0,1,32'h44, 10,6};
        vecs[13] = '{0,1,1,32'h40,32'h60, 0,0,32'h0,32'h0,0,0, 0,0,0,32'h0, 10,6};
        vecs[14] = '{1,1,1,32'h40,32'h60, 1,1,32'h40,32'h90,1,0, 0,0,0,32'h0, 10,6};
        vecs[15] = '{0,0,0,32'h0,32'h0, 1,1,32'hFFFFFFFC,32'h1234,1,0, 0,0,1,32'h0, 11,7};
        vecs[16] = '{0,1,1,32'h3C,32'h500, 1,1,32'h3C,32'h10,0,1, 0,0,1,32'h10, 12,8};
        vecs[17] = '{0,0,1,32'h100,32'h80, 0,1,32'h40,32'h90,1,0, 0,0,0,32'h0, 12,8};
        vecs[18] = '{0,1,0,32'h100,32'h80, 1,0,32'h40,32'h90,1,0, 0,0,0,32'h0, 12,8};

        idle();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        #1;
        check("reset_branch_count", 64'(branch_count), 64'd0);
        check("reset_mispredict_count", 64'(mispredict_count), 64'd0);
        check("reset_flush", 64'(flush), 64'd0);
        check("reset_id_pred", 64'(id_pred_taken), 64'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_id_pred", i), 64'(id_pred_taken), 64'(vecs[i].e_pred));
            check($sformatf("v%0d_id_redirect", i), 64'(id_redirect), 64'(vecs[i].e_idr));
            check($sformatf("v%0d_id_redirect_pc", i), 64'(id_redirect_pc), 64'(vecs[i].idtgt));
            check($sformatf("v%0d_flush", i), 64'(flush), 64'(vecs[i].e_flush));
            check($sformatf("v%0d_ex_redirect", i), 64'(ex_redirect), 64'(vecs[i].e_flush));
            check($sformatf("v%0d_ex_redirect_pc", i), 64'(ex_redirect_pc), 64'(vecs[i].e_rpc));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_branch_count", i), 64'(branch_count), 64'(vecs[i].e_bc));
            check($sformatf("v%0d_mispredict_count", i), 64'(mispredict_count), 64'(vecs[i].e_mc));
            $display("[TB] vec %0d: pred=%0b idr=%0b flush=%0b rpc=0x%08h bc=%0d mc=%0d",
                     i, vecs[i].e_pred, vecs[i].e_idr, vecs[i].e_flush, vecs[i].e_rpc,
                     vecs[i].e_bc, vecs[i].e_mc);
        end

        // Train idx 0 up to strong-taken, then reset asynchronously mid-cycle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle();
            ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h100; ex_target = 32'h80;
            ex_pred_taken = 1; ex_branch = 1;
            @(posedge clk);
        end
        @(negedge clk);
        idle();
        id_valid = 1; id_is_branch = 1; id_pc = 32'h100; id_target = 32'h80;
        #1;
        check("pre_reset_id_pred", 64'(id_pred_taken), 64'd1);
        check("pre_reset_branch_count", 64'(branch_count), 64'd14);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_branch_count", 64'(branch_count), 64'd0);
        check("async_reset_mispredict_count", 64'(mispredict_count), 64'd0);
        check("async_reset_id_pred", 64'(id_pred_taken), 64'd0);
        check("async_reset_flush", 64'(flush), 64'd0);
        $display("[TB] async reset pulse: counts=%0d/%0d pred=%0b", branch_count, mispredict_count, id_pred_taken);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_id_pred", 64'(id_pred_taken), 64'd0);
        check("post_reset_branch_count", 64'(branch_count), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 16; i++) m_cnt[i] = 1;
        m_bc = 0;
        m_mc = 0;
        for (int n = 0; n < 400; n++) begin
            int  id_i, ex_i;
            bit  id_act, ex_act, mis, e_pred;
            logic [31:0] e_rpc;
            @(negedge clk);
            stall         = ($urandom_range(0, 7) == 0);
            id_valid      = ($urandom_range(0, 3) != 0);
            id_is_branch  = ($urandom_range(0, 3) != 0);
            id_pc         = pick_pc();
            id_target     = $urandom;
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_is_branch  = ($urandom_range(0, 3) != 0);
            ex_pc         = pick_pc();
            ex_target     = $urandom;
            ex_pred_taken = 1'($urandom_range(0, 1));
            ex_branch     = 1'($urandom_range(0, 1));

            id_i   = int'((id_pc / 4) % 16);
            ex_i   = int'((ex_pc / 4) % 16);
            id_act = id_valid && id_is_branch && !stall;
            ex_act = ex_valid && ex_is_branch && !stall;
            mis    = ex_act && (ex_branch != ex_pred_taken);
            e_pred = id_act && (m_cnt[id_i] >= 2);
            e_rpc  = !mis ? 32'h0 : (ex_branch ? ex_target : ex_pc + 32'd4);
            #1;
            check("rnd_id_pred", 64'(id_pred_taken), 64'(e_pred));
            check("rnd_id_redirect", 64'(id_redirect), 64'(e_pred && !mis));
            check("rnd_flush", 64'(flush), 64'(mis));
            check("rnd_ex_redirect_pc", 64'(ex_redirect_pc), 64'(e_rpc));
            @(posedge clk);
            if (ex_act) begin
                if (ex_branch) m_cnt[ex_i] = (m_cnt[ex_i] == 3) ? 3 : m_cnt[ex_i] + 1;
                else           m_cnt[ex_i] = (m_cnt[ex_i] == 0) ? 0 : m_cnt[ex_i] - 1;
                m_bc = m_bc + 1;
                if (mis) m_mc = m_mc + 1;
            end
            #1;
            check("rnd_branch_count", 64'(branch_count), 64'(m_bc));
            check("rnd_mispredict_count", 64'(mispredict_count), 64'(m_mc));
        end
        $display("[TB] random phase: %0d branches, %0d mispredicts", m_bc, m_mc);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch prediction and resolution controller for the in-order core.
- Holds a table of 2-bit saturating counters indexed by PC.
- In ID: predicts conditional branches and steers fetch to the decoded target.
- In EX: consumes the cmp unit's resolved branch flag, detects mispredictions, flushes the younger stages, redirects fetch and trains the table.

Parameters:
- XLEN, 32, PC/target width.
- BHT_ENTRIES, 16, number of counters; power of two, 2..256.
- CNT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_stall  in  1  pipeline stall; ID prediction, EX resolution and table/statistics updates are suppressed.
- i_id_valid  in  1  ID holds a valid instruction.
- i_id_is_branch  in  1  ID instruction is a conditional branch.
- i_id_pc  in  XLEN  ID instruction PC.
- i_id_target  in  XLEN  decoded branch target.
- o_id_pred_taken  out  1  prediction; carried down the pipe to EX.
- o_id_redirect  out  1  steer fetch to i_id_target this cycle.
- o_id_redirect_pc  out  XLEN  equals i_id_target.
- i_ex_valid  in  1  EX holds a valid instruction.
- i_ex_is_branch  in  1  EX instruction is a conditional branch.
- i_ex_pc  in  XLEN  EX instruction PC.
- i_ex_target  in  XLEN  branch target.
- i_ex_pred_taken  in  1  prediction made for this instruction in ID.
- i_ex_branch  in  1  resolved outcome from cmp o_branch.
- o_flush  out  1  squash IF/ID contents.
- o_ex_redirect  out  1  EX redirect valid.
- o_ex_redirect_pc  out  XLEN  corrected fetch PC.
- o_branch_count  out  CNT_W  resolved branches.
- o_mispredict_count  out  CNT_W  mispredictions.

Behaviour:
- Index: idx(pc) = pc[2 +: log2(BHT_ENTRIES)].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = counter[1].
- Reset (async, on i_rst high):
  - every counter = 01;
  - o_branch_count = 0, o_mispredict_count = 0;
  - combinational outputs are 0 while inputs are idle.
- ID prediction (combinational, zero latency):
  - id_act = i_id_valid & i_id_is_branch & ~i_stall.
  - o_id_pred_taken = id_act & bht[idx(i_id_pc)][1].
  - o_id_redirect = o_id_pred_taken & ~mispredict.
  - o_id_redirect_pc = i_id_target.
- EX resolution (combinational, same cycle):
  - ex_act = i_ex_valid & i_ex_is_branch & ~i_stall.
  - mispredict = ex_act & (i_ex_branch != i_ex_pred_taken).
  - o_flush = o_ex_redirect = mispredict.
  - o_ex_redirect_pc = i_ex_branch ? i_ex_target : i_ex_pc + 4 (wraps modulo 2^XLEN).
  - Drive o_ex_redirect_pc as 0 when mispredict is 0.
- Training (rising edge when ex_act):
  - counter at idx(i_ex_pc) increments if i_ex_branch, else decrements;
  - saturates at 11 and 00.
  - o_branch_count += 1; o_mispredict_count += mispredict.
  - Both statistics counters wrap at 2^CNT_W.
- Simultaneous events:
  - EX mispredict and ID predicted-taken in the same cycle: EX wins, o_id_redirect = 0.
  - ID read and EX write to the same index in the same cycle: ID reads the pre-update value (no bypass).
- Stall: no outputs assert; table and statistics hold.
- Reset mid-operation: state clears immediately; no pending redirect survives.
- Aliasing: PCs differing only above the index bits share a counter.

Test Plan:
- Reset, then ID branch at pc=0x100, target 0x80 -> o_id_pred_taken=0, o_id_redirect=0; both statistics counters read 0.
- EX branch pc=0x100, pred=0, branch=1, target=0x80, repeated 3 cycles -> o_flush=1 and o_ex_redirect_pc=0x80 on cycles 1 and 2 only. Counter path 01→10→11→11; ID at 0x100 then predicts taken with o_id_redirect_pc=0x80. Final counts: o_branch_count=3, o_mispredict_count=2.
- EX branch pc=0x200, pred=1, branch=0 -> o_flush=1, o_ex_redirect_pc=0x204. Same with pred=0, branch=0 -> no flush, counter at idx 0 saturates at 00.
- Same cycle: EX mispredict at pc=0x40 and ID taken-predicted branch -> o_id_redirect=0, o_ex_redirect=1. ID at idx(0x40) sees the old counter; the new value is visible the next cycle.
- i_stall=1 with a mispredicting EX branch -> o_flush=0, statistics unchanged. i_rst pulsed mid-run, asynchronous to the clock edge -> counters revert to 01 and statistics to 0 immediately.
- EX pc=0xFFFFFFFC, pred=1, branch=0 -> o_ex_redirect_pc=0x00000000 (wrap).
